conv_param_loader: RTL

//  Sequencer that loads one Conv2D layer's parameters from its read-only param ROMs (1-cycle read latency) into the Conv2D engine on a start pulse.

---
 rtl/conv_param_loader.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_param_loader.sv
// conv_param_loader
// Loads one Conv2D layer from its ROMs: streams every kernel word with its
// och/tap/ich tags over a valid/ready port, then one bias/requant beat per
// output channel. z3 is captured on the first param beat.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start_i; the first weight read goes out on accept
// S_LOAD_W  | issuing weight reads whenever the kernel buffer has room
// S_DRAIN_W | every read issued, waiting for the kernel buffer to empty
// S_LOAD_P  | one param ROM read per output channel, then the last beat
// S_DONE    | one-cycle completion pulse
module conv_param_loader #(
   parameter int F_IN_D      = 1,
   parameter int F_OUT_D     = 4,
   parameter int KERNEL_SIZE = 3,
   parameter int W_RES       = 8,
   parameter int B_RES       = 32,
   parameter int W_AW        = 12,
   parameter int B_AW        = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             wrom_en_o,
   output logic [W_AW-1:0]  wrom_addr_o,
   input  logic [W_RES-1:0] wrom_data_i,
   output logic             prom_en_o,
   output logic [B_AW-1:0]  prom_addr_o,
   input  logic [B_RES-1:0] bias_i,
   input  logic [B_RES-1:0] m0_i,
   input  logic [B_RES-1:0] b_i,
   input  logic [4:0]       n_i,
   input  logic [W_RES-1:0] z3_i,
   output logic             kw_valid_o,
   input  logic             kw_ready_i,
   output logic [W_RES-1:0] kw_data_o,
   output logic [W_AW-1:0]  kw_tap_o,
   output logic [W_AW-1:0]  kw_ich_o,
   output logic [W_AW-1:0]  kw_och_o,
   output logic             cp_valid_o,
   output logic [B_AW-1:0]  cp_och_o,
   output logic [B_RES-1:0] cp_bias_o,
   output logic [B_RES-1:0] cp_m0_o,
   output logic [B_RES-1:0] cp_b_o,
   output logic [4:0]       cp_n_o,
   output logic [W_RES-1:0] z3_o
);

   localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
   localparam logic [W_AW-1:0] TAP_LAST  = W_AW'(KK - 1);
   localparam logic [W_AW-1:0] ICH_LAST  = W_AW'(F_IN_D - 1);
   localparam logic [W_AW-1:0] OCH_LAST  = W_AW'(F_OUT_D - 1);
   localparam logic [W_AW-1:0] OCH_STRD  = W_AW'(KK * F_IN_D);
   localparam logic [W_AW-1:0] TAP_STRD  = W_AW'(F_IN_D);
   localparam logic [B_AW:0]   P_CNT_END = (B_AW + 1)'(F_OUT_D);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_DRAIN_W, S_LOAD_P, S_DONE
   } state_t;

   state_t r_state, w_state_nxt;

   logic [W_AW-1:0]  r_tap, r_ich, r_och;
   logic             r_rd_pend;
   logic [W_AW-1:0]  r_pd_tap, r_pd_ich, r_pd_och;
   logic             r_kw_valid;
   logic [W_RES-1:0] r_kw_data;
   logic [W_AW-1:0]  r_kw_tap, r_kw_ich, r_kw_och;
   logic             r_sk_valid;
   logic [W_RES-1:0] r_sk_data;
   logic [W_AW-1:0]  r_sk_tap, r_sk_ich, r_sk_och;
   logic [B_AW:0]    r_pcnt;
   logic             r_p_pend;
   logic [B_AW-1:0]  r_cp_och;
   logic [B_RES-1:0] r_cp_bias, r_cp_m0, r_cp_b;
   logic [4:0]       r_cp_n;
   logic [W_RES-1:0] r_z3;

   logic             w_issue, w_pen, w_last, w_xfer, w_first;
   logic [1:0]       w_occ;
   logic [W_AW-1:0]  w_waddr;

   assign w_xfer  = r_kw_valid & kw_ready_i;
   assign w_last  = (r_tap == TAP_LAST) & (r_ich == ICH_LAST) & (r_och == OCH_LAST);
   assign w_waddr = r_och * OCH_STRD + r_tap * TAP_STRD + r_ich;
   // Entries that will still be held after this cycle: buffered words plus
   // the read in flight, minus the one leaving. A new read needs one free slot.
   assign w_occ   = 2'(r_kw_valid) + 2'(r_sk_valid) + 2'(r_rd_pend) - 2'(w_xfer);
   assign w_first = r_p_pend & (r_cp_och == '0);

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // next state, weight read issue and param read enable
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_pen       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_issue     = 1'b1;
               w_state_nxt = w_last ? S_DRAIN_W : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (w_occ <= 2'd1) begin
               w_issue = 1'b1;
               if (w_last) w_state_nxt = S_DRAIN_W;
            end
         end
         S_DRAIN_W: begin
            if (!r_kw_valid && !r_sk_valid && !r_rd_pend) w_state_nxt = S_LOAD_P;
         end
         S_LOAD_P: begin
            if (r_pcnt == P_CNT_END) w_state_nxt = S_DONE;
            else                     w_pen = 1'b1;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // weight counters (ich innermost so addresses run sequentially) and the
   // tags of the read in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tap     <= '0;
         r_ich     <= '0;
         r_och     <= '0;
         r_rd_pend <= 1'b0;
         r_pd_tap  <= '0;
         r_pd_ich  <= '0;
         r_pd_och  <= '0;
      end else begin
         r_rd_pend <= w_issue;
         if (w_issue) begin
            r_pd_tap <= r_tap;
            r_pd_ich <= r_ich;
            r_pd_och <= r_och;
            if (r_ich == ICH_LAST) begin
               r_ich <= '0;
               if (r_tap == TAP_LAST) begin
                  r_tap <= '0;
                  r_och <= (r_och == OCH_LAST) ? '0 : r_och + 1'b1;
               end else begin
                  r_tap <= r_tap + 1'b1;
               end
            end else begin
               r_ich <= r_ich + 1'b1;
            end
         end
      end
   end

   // kernel word buffer: output register plus a one-entry skid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_kw_valid <= 1'b0;
         r_kw_data  <= '0;
         r_kw_tap   <= '0;
         r_kw_ich   <= '0;
         r_kw_och   <= '0;
         r_sk_valid <= 1'b0;
         r_sk_data  <= '0;
         r_sk_tap   <= '0;
         r_sk_ich   <= '0;
         r_sk_och   <= '0;
      end else if (w_xfer || !r_kw_valid) begin
         if (r_sk_valid) begin
            r_kw_valid <= 1'b1;
            r_kw_data  <= r_sk_data;
            r_kw_tap   <= r_sk_tap;
            r_kw_ich   <= r_sk_ich;
            r_kw_och   <= r_sk_och;
            r_sk_valid <= r_rd_pend;
            if (r_rd_pend) begin
               r_sk_data <= wrom_data_i;
               r_sk_tap  <= r_pd_tap;
               r_sk_ich  <= r_pd_ich;
               r_sk_och  <= r_pd_och;
            end
         end else if (r_rd_pend) begin
            r_kw_valid <= 1'b1;
            r_kw_data  <= wrom_data_i;
            r_kw_tap   <= r_pd_tap;
            r_kw_ich   <= r_pd_ich;
            r_kw_och   <= r_pd_och;
         end else begin
            r_kw_valid <= 1'b0;
         end
      end else if (r_rd_pend) begin
         r_sk_valid <= 1'b1;
         r_sk_data  <= wrom_data_i;
         r_sk_tap   <= r_pd_tap;
         r_sk_ich   <= r_pd_ich;
         r_sk_och   <= r_pd_och;
      end
   end

   // param phase: channel counter, beat flag and held beat values
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pcnt    <= '0;
         r_p_pend  <= 1'b0;
         r_cp_och  <= '0;
         r_cp_bias <= '0;
         r_cp_m0   <= '0;
         r_cp_b    <= '0;
         r_cp_n    <= '0;
         r_z3      <= '0;
      end else begin
         r_p_pend <= w_pen;
         if (r_state == S_LOAD_P) r_pcnt <= (r_pcnt == P_CNT_END) ? '0 : r_pcnt + 1'b1;
         if (w_pen) r_cp_och <= r_pcnt[B_AW-1:0];
         if (r_p_pend) begin
            r_cp_bias <= bias_i;
            r_cp_m0   <= m0_i;
            r_cp_b    <= b_i;
            r_cp_n    <= n_i;
         end
         if (w_first) r_z3 <= z3_i;
      end
   end

   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign wrom_en_o   = w_issue;
   assign wrom_addr_o = w_waddr;
   assign prom_en_o   = w_pen;
   assign prom_addr_o = w_pen ? r_pcnt[B_AW-1:0] : '0;
   assign kw_valid_o  = r_kw_valid;
   assign kw_data_o   = r_kw_data;
   assign kw_tap_o    = r_kw_tap;
   assign kw_ich_o    = r_kw_ich;
   assign kw_och_o    = r_kw_och;
   // beat data comes straight from the ROMs on the beat cycle, held afterwards
   assign cp_valid_o  = r_p_pend;
   assign cp_och_o    = r_cp_och;
   assign cp_bias_o   = r_p_pend ? bias_i : r_cp_bias;
   assign cp_m0_o     = r_p_pend ? m0_i   : r_cp_m0;
   assign cp_b_o      = r_p_pend ? b_i    : r_cp_b;
   assign cp_n_o      = r_p_pend ? n_i    : r_cp_n;
   assign z3_o        = w_first  ? z3_i   : r_z3;

endmodule
